// File: rtl/lcd_pkg.sv
`timescale 1ns/1ps
// Shared types for the LCD command issuer: FSM state encoding and the
// LCD controller command codes.
package lcd_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_LATCH     = 4'd2,
        S_WAIT_RDY  = 4'd3,
        S_ISSUE     = 4'd4,
        S_GUARD     = 4'd5,
        S_GUARD_END = 4'd6,
        S_WAIT_DONE = 4'd7,
        S_FINISH    = 4'd8
    } state_t;

    localparam logic [3:0] CMD_WRITE  = 4'd0;
    localparam logic [3:0] CMD_UP     = 4'd1;
    localparam logic [3:0] CMD_DOWN   = 4'd2;
    localparam logic [3:0] CMD_LEFT   = 4'd3;
    localparam logic [3:0] CMD_RIGHT  = 4'd4;
    localparam logic [3:0] CMD_MAX_OP = 4'd5;
    localparam logic [3:0] CMD_MIN_OP = 4'd6;
    localparam logic [3:0] CMD_AVG    = 4'd7;
    localparam logic [3:0] CMD_CCW    = 4'd8;
    localparam logic [3:0] CMD_CW     = 4'd9;
    localparam logic [3:0] CMD_MIRX   = 4'd10;
    localparam logic [3:0] CMD_MIRY   = 4'd11;

    localparam logic [7:0] ISSUED_SAT = 8'hFF;

endpackage

// File: rtl/lcd_cmd_issuer.sv
`timescale 1ns/1ps
// Walks a CROM command script, issuing each legal command to the LCD controller
// and closing with a WRITE. Define LCD_IRAM_CHKSUM_EN to add the IRAM checksum.
module lcd_cmd_issuer
    import lcd_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int CMD_MAX = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              CROM_rd,
    output logic [ADDR_W-1:0] CROM_A,
    input  logic [3:0]        CROM_Q,
    output logic [3:0]        cmd,
    output logic              cmd_valid,
    input  logic              busy,
    input  logic              done,
    output logic              finished,
    output logic [7:0]        n_issued,
    output logic [15:0]       chksum,
`ifdef LCD_IRAM_CHKSUM_EN
    input  logic              IRAM_valid,
    input  logic [7:0]        IRAM_D,
`endif
    output state_t            dbg_state
);

    // Handshake: cmd_valid is high for exactly one cycle per command with cmd
    // holding the code; cmd is 0 whenever cmd_valid is 0. A command is only
    // issued after busy was sampled low, and the script ends once done is
    // sampled high after the closing WRITE.

    localparam logic [ADDR_W-1:0] LAST_PTR  = '1;
    localparam logic [3:0]        CMD_LIMIT = 4'(CMD_MAX);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   ptr, ptr_n, addr_n;
    logic [3:0]          cmd_reg, cmd_reg_n, cmd_n;
    logic                rd_n, valid_n, fin_n;
    logic [7:0]          count_n;

    assign dbg_state = state;

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cmd_reg_n = cmd_reg;
        count_n   = n_issued;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    ptr_n   = '0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH:  state_n = S_LATCH;
            S_LATCH: begin
                cmd_reg_n = CROM_Q;
                if (CROM_Q > CMD_LIMIT) begin
                    // Illegal code: skip it, unless it was the last entry, in
                    // which case the script still has to close with a WRITE.
                    if (ptr == LAST_PTR) begin
                        cmd_reg_n = CMD_WRITE;
                        state_n   = S_WAIT_RDY;
                    end else begin
                        ptr_n   = ptr + 1'b1;
                        state_n = S_FETCH;
                    end
                end else begin
                    state_n = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (!busy) state_n = S_ISSUE;
            end
            S_ISSUE: begin
                if (n_issued != ISSUED_SAT) count_n = n_issued + 8'd1;
                if (cmd_reg == CMD_WRITE) begin
                    state_n = S_WAIT_DONE;
                end else if (ptr == LAST_PTR) begin
                    cmd_reg_n = CMD_WRITE;
                    state_n   = S_GUARD_END;
                end else begin
                    ptr_n   = ptr + 1'b1;
                    state_n = S_GUARD;
                end
            end
            // The controller raises busy one cycle late, so this cycle must not look at it.
            S_GUARD:     state_n = S_FETCH;
            S_GUARD_END: state_n = S_WAIT_RDY;
            S_WAIT_DONE: begin
                if (done) state_n = S_FINISH;
            end
            S_FINISH:    state_n = S_FINISH;
            default:     state_n = S_IDLE;
        endcase

        // Outputs are registered copies of what the next state presents.
        rd_n    = (state_n == S_FETCH);
        addr_n  = rd_n ? ptr_n : CROM_A;
        valid_n = (state_n == S_ISSUE);
        cmd_n   = valid_n ? cmd_reg_n : CMD_WRITE;
        fin_n   = (state_n == S_FINISH);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cmd_reg   <= CMD_WRITE;
            CROM_rd   <= 1'b0;
            CROM_A    <= '0;
            cmd       <= CMD_WRITE;
            cmd_valid <= 1'b0;
            finished  <= 1'b0;
            n_issued  <= 8'd0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cmd_reg   <= cmd_reg_n;
            CROM_rd   <= rd_n;
            CROM_A    <= addr_n;
            cmd       <= cmd_n;
            cmd_valid <= valid_n;
            finished  <= fin_n;
            n_issued  <= count_n;
        end
    end

`ifdef LCD_IRAM_CHKSUM_EN
    logic [15:0] chk_n;

    always_comb begin
        chk_n = chksum;
        if (state == S_WAIT_DONE && IRAM_valid) chk_n = chksum + {8'h00, IRAM_D};
    end

    always_ff @(posedge clk) begin
        if (!reset) chksum <= 16'h0000;
        else        chksum <= chk_n;
    end
`else
    assign chksum = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
`timescale 1ns/1ps
// Bench for lcd_cmd_issuer: table-driven and random CROM scripts against a
// script-level command model, plus reset and ADDR_W=2 corner sequences.
module tb_lcd_cmd_issuer;
    import lcd_pkg::*;

    localparam int DEPTH = 32;

    // ---------------- clock / DUT signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, busy, done;
    logic        CROM_rd, cmd_valid, finished;
    logic [4:0]  CROM_A;
    logic [3:0]  CROM_Q, cmd;
    logic [7:0]  n_issued;
    logic [15:0] chksum;
    state_t      dbg_state;

    logic        s2_start, s2_busy, s2_done, s2_rd, s2_valid, s2_fin;
    logic [1:0]  s2_a;
    logic [3:0]  s2_q, s2_cmd;
    logic [7:0]  s2_n;
    logic [15:0] s2_chk;
    state_t      s2_state;

`ifdef LCD_IRAM_CHKSUM_EN
    logic        IRAM_valid, s2_iram_valid;
    logic [7:0]  IRAM_D, s2_iram_d;
`endif

    lcd_cmd_issuer #(.ADDR_W(5), .CMD_MAX(11)) dut (
        .clk(clk), .reset(reset), .start(start),
        .CROM_rd(CROM_rd), .CROM_A(CROM_A), .CROM_Q(CROM_Q),
        .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
        .finished(finished), .n_issued(n_issued), .chksum(chksum),
`ifdef LCD_IRAM_CHKSUM_EN
        .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D),
`endif
        .dbg_state(dbg_state)
    );

    lcd_cmd_issuer #(.ADDR_W(2), .CMD_MAX(11)) dut2 (
        .clk(clk), .reset(reset), .start(s2_start),
        .CROM_rd(s2_rd), .CROM_A(s2_a), .CROM_Q(s2_q),
        .cmd(s2_cmd), .cmd_valid(s2_valid), .busy(s2_busy), .done(s2_done),
        .finished(s2_fin), .n_issued(s2_n), .chksum(s2_chk),
`ifdef LCD_IRAM_CHKSUM_EN
        .IRAM_valid(s2_iram_valid), .IRAM_D(s2_iram_d),
`endif
        .dbg_state(s2_state)
    );

    // ---------------- scoreboard state ----------------
    int vec_cnt = 0;
    int err_cnt = 0;

    logic [3:0] rom [DEPTH];
    logic [3:0] rom2 [4];
    logic [3:0] exp_q[$];
    int         gap_q[$];
    logic [3:0] s2_got[$];

    bit         mon_en = 1'b0;
    bit         wrote, fin_exp, wd, iram_ff;
    int         cyc, last_cyc, busy_cnt, busy_max, done_cnt, done_delay, iram_left, rd_cnt, g;
    logic [4:0] rd_exp_a;
    logic [3:0] e;
    logic [15:0] chk_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Expected strobes from the script rules: skip codes above 11, stop after
    // the first WRITE, otherwise append a WRITE after the last entry.
    task automatic build_model();
        bit term = 1'b0;
        exp_q.delete();
        gap_q.delete();
        for (int i = 0; i < DEPTH && !term; i++) begin
            if (rom[i] <= 4'd11) begin
                exp_q.push_back(rom[i]);
                gap_q.push_back(4);
                if (rom[i] == 4'd0) term = 1'b1;
            end
        end
        if (!term) begin
            exp_q.push_back(4'd0);
            gap_q.push_back((rom[DEPTH-1] <= 4'd11) ? 3 : 4);
        end
    endtask

    // ---------------- CROM responders, monitor, controller model ----------------
    always @(negedge clk) begin
        if (CROM_rd) CROM_Q = rom[CROM_A];
        if (s2_rd) s2_q = rom2[s2_a];
        if (s2_valid) s2_got.push_back(s2_cmd);
        if (mon_en) begin
            cyc++;
            wd = wrote && !fin_exp;
            check("finished", {31'd0, finished}, {31'd0, fin_exp});
            check("chksum", {16'd0, chksum}, {16'd0, chk_exp});
            if (CROM_rd) begin
                check("crom_addr", {27'd0, CROM_A}, {27'd0, rd_exp_a});
                rd_exp_a++;
                rd_cnt++;
            end
            if (cmd_valid) begin
                check("busy_at_strobe", {31'd0, busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL extra_strobe: got cmd %0d, expected no strobe", cmd);
                end else begin
                    g = gap_q.pop_front();
                    e = exp_q.pop_front();
                    check("cmd", {28'd0, cmd}, {28'd0, e});
                    check("strobe_gap_ok", {31'd0, (cyc - last_cyc) >= g}, 32'd1);
                    if (exp_q.size() == 0) begin
                        wrote     = 1'b1;
                        done_cnt  = done_delay;
                        iram_left = 64;
                    end
                end
                last_cyc = cyc;
            end else begin
                check("cmd_idle_zero", {28'd0, cmd}, 32'd0);
            end
            if (busy_cnt > 0) begin
                busy = 1'b1;
                busy_cnt--;
            end else begin
                busy = 1'b0;
            end
            if (cmd_valid) busy_cnt = $urandom_range(0, busy_max);
            if (!wrote) begin
                done = 1'($urandom_range(0, 1));
            end else if (done_cnt > 0) begin
                done = 1'b0;
                done_cnt--;
            end else begin
                done = 1'b1;
            end
`ifdef LCD_IRAM_CHKSUM_EN
            if (iram_ff) begin
                IRAM_valid = wd && (iram_left > 0);
                IRAM_D     = 8'hFF;
                if (IRAM_valid) iram_left--;
            end else begin
                IRAM_valid = 1'($urandom_range(0, 1));
                IRAM_D     = 8'($urandom_range(0, 255));
            end
            if (wd && IRAM_valid) chk_exp = chk_exp + {8'h00, IRAM_D};
`endif
            fin_exp = fin_exp || (wd && done);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_vals(input string tag);
        check({tag, "_crom_rd"}, {31'd0, CROM_rd}, 32'd0);
        check({tag, "_crom_a"}, {27'd0, CROM_A}, 32'd0);
        check({tag, "_cmd"}, {28'd0, cmd}, 32'd0);
        check({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
        check({tag, "_finished"}, {31'd0, finished}, 32'd0);
        check({tag, "_n_issued"}, {24'd0, n_issued}, 32'd0);
        check({tag, "_chksum"}, {16'd0, chksum}, 32'd0);
        check({tag, "_state"}, {28'd0, dbg_state}, {28'd0, S_IDLE});
    endtask

    task automatic do_reset(input int load);
        mon_en = 1'b0;
        step();
        reset = 1'b0;
        start = 1'b0;
        busy  = (load > 0);
        done  = 1'b0;
`ifdef LCD_IRAM_CHKSUM_EN
        IRAM_valid = 1'b0;
        IRAM_D     = 8'h00;
`endif
        step();
        step();
        check_reset_vals("reset");
        cyc = 0; last_cyc = -1000; wrote = 1'b0; fin_exp = 1'b0; chk_exp = 16'h0;
        rd_exp_a = 5'd0; rd_cnt = 0; busy_cnt = load; done_cnt = 0; iram_left = 0;
        reset = 1'b1;
    endtask

    task automatic run_script(input int exp_n, input int dly, input int bmax, input int load, input bit ff);
        int k;
        int n_exp;
        build_model();
        n_exp = (exp_n < 0) ? ((exp_q.size() > 255) ? 255 : exp_q.size()) : exp_n;
        do_reset(load);
        done_delay = dly;
        busy_max   = bmax;
        iram_ff    = ff;
        mon_en     = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4000 && !finished; i++) step();
        if (!finished) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL finish_timeout: finished still 0 after 4000 cycles, expected 1");
        end
        step();
        step();
        check("all_strobes_seen", exp_q.size(), 32'd0);
        check("n_issued", {24'd0, n_issued}, n_exp);
`ifdef LCD_IRAM_CHKSUM_EN
        if (ff) check("chksum_ff", {16'd0, chksum}, 32'h3FC0);
`else
        check("chksum_zero", {16'd0, chksum}, 32'd0);
`endif
        k = rd_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check("no_fetch_after_finish", rd_cnt, k);
        check("finished_sticky", {31'd0, finished}, 32'd1);
        mon_en = 1'b0;
    endtask

    task automatic load_script(input logic [31:0] hex);
        for (int i = 0; i < DEPTH; i++) rom[i] = (i < 8) ? hex[4*i +: 4] : 4'hC;
    endtask

    // ---------------- stimulus table ----------------
    // script: nibble i is CROM entry i for i < 8; entries 8..31 hold 12 (skipped).
    typedef struct {
        logic [31:0] script;
        int          exp_n;
        int          done_delay;
        int          busy_max;
    } vec_t;

    vec_t tbl[5];
    logic [3:0] exp2 [5];

    initial begin
        tbl[0] = '{32'hCCCC_0724, 4, 70, 3};   // {4,2,7,0}
        tbl[1] = '{32'hCCCC_05FC, 2, 5, 4};    // {12,15,5,0}
        tbl[2] = '{32'hCCCC_CCC0, 1, 0, 2};    // {0}: immediate WRITE
        tbl[3] = '{32'hCCC0_1BD3, 4, 3, 6};    // {3,13,11,1,0}
        tbl[4] = '{32'hCCCC_CC89, 3, 10, 5};   // {9,8,12...}: WRITE forced at last entry
        exp2   = '{4'd1, 4'd3, 4'd9, 4'd8, 4'd0};

        reset = 1'b0; start = 1'b0; busy = 1'b0; done = 1'b0; CROM_Q = 4'd0;
        s2_start = 1'b0; s2_busy = 1'b0; s2_done = 1'b0; s2_q = 4'd0;
`ifdef LCD_IRAM_CHKSUM_EN
        IRAM_valid = 1'b0; IRAM_D = 8'h00; s2_iram_valid = 1'b0; s2_iram_d = 8'h00;
`endif
        for (int i = 0; i < 4; i++) rom2[i] = 4'd0;

        for (int t = 0; t < 5; t++) begin
            load_script(tbl[t].script);
            run_script(tbl[t].exp_n, tbl[t].done_delay, tbl[t].busy_max, 66, t == 0);
        end

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) rom[i] = 4'($urandom_range(0, 15));
            run_script(-1, $urandom_range(0, 20), $urandom_range(0, 8), $urandom_range(0, 70), 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) rom[i] = 4'($urandom_range(1, 11));
        run_script(33, $urandom_range(0, 20), $urandom_range(0, 6), 10, 1'b0);

        // Reset pulse while waiting to issue the second command.
        load_script(32'hCCCC_0724);
        do_reset(0);
        busy = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50 && !cmd_valid; i++) step();
        check("mid_first_strobe", {31'd0, cmd_valid}, 32'd1);
        check("mid_first_cmd", {28'd0, cmd}, 32'd4);
        busy = 1'b1;
        repeat (5) step();
        check("mid_in_wait_rdy", {28'd0, dbg_state}, {28'd0, S_WAIT_RDY});
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_reset_vals("mid_reset");
        busy = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_crom_rd", {31'd0, CROM_rd}, 32'd1);
        check("restart_crom_a", {27'd0, CROM_A}, 32'd0);

        // ADDR_W=2 instance, script without a WRITE; done held high throughout.
        rom2[0] = 4'd1; rom2[1] = 4'd3; rom2[2] = 4'd9; rom2[3] = 4'd8;
        do_reset(0);
        s2_got.delete();
        s2_done = 1'b1;
        s2_busy = 1'b0;
        step();
        s2_start = 1'b1;
        step();
        s2_start = 1'b0;
        for (int i = 0; i < 300 && !s2_fin; i++) step();
        check("aw2_finished", {31'd0, s2_fin}, 32'd1);
        check("aw2_strobe_count", s2_got.size(), 32'd5);
        for (int i = 0; i < 5 && i < s2_got.size(); i++)
            check("aw2_cmd", {28'd0, s2_got[i]}, {28'd0, exp2[i]});
        check("aw2_n_issued", {24'd0, s2_n}, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
